regfile_wb_arbiter: RTL

Shares the single write port of the 8x16 register file between two writeback requesters: the ALU result path and the memory load path. Each requester uses a valid/ready handshake. The block applies fixed priority with starvation protection, registers the write-port drive, and keeps a per-register pending-write scoreboard that the issue stage uses for hazard stalls. It sits between the execute/memory stages and the register file write port.

---
 rtl/regfile_wb_arbiter_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_wb_scoreboard.sv | 39 +++
 rtl/regfile_wb_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and encodings for the writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 16;
  localparam int NUM_REGS   = 8;

  typedef enum logic {
    NORMAL    = 1'b0,
    FORCE_ALU = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_MEM = 1'b0,
    REQ_ALU = 1'b1
  } req_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write bitmap: flush beats reserve, reserve beats the accept-clear.
module wb_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n_i,
  input  logic                flush_i,
  input  logic                reserve_en_i,
  input  logic [ADDR_W-1:0]   reserve_addr_i,
  input  logic                clr_en_i,
  input  logic [ADDR_W-1:0]   clr_addr_i,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reserve_en_i && (reserve_addr_i == ADDR_W'(i)))
          busy_d[i] = 1'b1;
        else if (clr_en_i && (clr_addr_i == ADDR_W'(i)))
          busy_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between the MEM and ALU writeback
// paths (MEM priority, ALU starvation guard) and tracks pending writes.
module regfile_wb_arbiter #(
  parameter int NUM_REGS     = regfile_wb_arbiter_pkg::NUM_REGS,
  parameter int ADDR_W       = regfile_wb_arbiter_pkg::REG_ADDR_W,
  parameter int DATA_W       = regfile_wb_arbiter_pkg::REG_DATA_W,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  input  logic                reserve_en,
  input  logic [ADDR_W-1:0]   reserve_addr,
  input  logic                flush,
  output logic                write_enable,
  output logic [ADDR_W-1:0]   write_addr,
  output logic [DATA_W-1:0]   write_data,
  output logic [NUM_REGS-1:0] busy
);

  import regfile_wb_arbiter_pkg::*;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               accept;
  req_e               winner;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!reset || flush) begin
      state_d = NORMAL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        NORMAL: begin
          if (mem_valid) begin
            mem_ready = 1'b1;
            if (alu_valid) begin
              cnt_d = cnt_q + 1'b1;
              if (cnt_d == CNT_W'(STARVE_LIMIT)) state_d = FORCE_ALU;
            end else begin
              cnt_d = '0;
            end
          end else begin
            alu_ready = alu_valid;
            cnt_d     = '0;
          end
        end
        FORCE_ALU: begin
          // One forced slot, used or not, then back to MEM priority.
          alu_ready = alu_valid;
          state_d   = NORMAL;
          cnt_d     = '0;
        end
        default: begin
          state_d = NORMAL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign winner   = (alu_valid && alu_ready) ? REQ_ALU : REQ_MEM;
  assign accept   = (alu_valid && alu_ready) || (mem_valid && mem_ready);
  assign win_addr = (winner == REQ_ALU) ? alu_addr : mem_addr;
  assign win_data = (winner == REQ_ALU) ? alu_data : mem_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= accept;
      if (accept) begin
        waddr_q <= win_addr;
        wdata_q <= win_data;
      end
    end
  end

  assign write_enable = we_q;
  assign write_addr   = waddr_q;
  assign write_data   = wdata_q;

  wb_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk            (clk),
    .rst_n_i        (reset),
    .flush_i        (flush),
    .reserve_en_i   (reserve_en),
    .reserve_addr_i (reserve_addr),
    .clr_en_i       (accept),
    .clr_addr_i     (win_addr),
    .busy_o         (busy)
  );

endmodule
